// File: rtl/efuse_pkg.sv
// Shared types and constants for the efuse access arbiter.
// Imported by the arbiter top and its round-robin helper.
package efuse_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT_DONE,
        S_ACK,
        S_GAP,
        S_DRAIN
    } state_t;

    localparam int LOCK_BIT_DEF = 31;
    localparam int REQ_BOOT     = 0;
    localparam int REQ_HOST     = 1;

endpackage

// File: rtl/efuse_rr_arb.sv
// Two-way round-robin arbiter.
// The pointer holds the last winner and moves only on advance.
module efuse_rr_arb
    import efuse_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx
);

    logic ptr;

    always_comb begin
        gnt_idx = ptr;
        case (req)
            2'b01:   gnt_idx = 1'(REQ_BOOT);
            2'b10:   gnt_idx = 1'(REQ_HOST);
            2'b11:   gnt_idx = ~ptr;
            default: gnt_idx = ptr;
        endcase
    end

    // Reset pointer at the host port so the boot port wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'(REQ_HOST);
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/efuse_access_arbiter.sv
// Shares one efuse_controller port between boot and host requesters,
// runs the boot read, keeps a shadow word and enforces lock and timeout.
module efuse_access_arbiter
    import efuse_pkg::*;
#(
    parameter int M        = 32,
    parameter int TIMEOUT  = 4096,
    parameter int LOCK_BIT = LOCK_BIT_DEF
) (
    input  logic           clk_div2,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic [1:0]     req_wr,
    input  logic [2*M-1:0] req_wdata,
    output logic [1:0]     gnt,
    output logic [1:0]     rsp_valid,
    output logic           rsp_err,
    output logic [M-1:0]   rsp_rdata,
    output logic [M-1:0]   shadow,
    output logic           boot_done,
    output logic           err_sticky,
    output logic           lock,
    output logic           efc_rd,
    output logic           efc_wr,
    output logic           efc_ack,
    output logic [M-1:0]   efc_data_in,
    input  logic [M-1:0]   efc_data_out,
    input  logic           efc_rd_done,
    input  logic           efc_wr_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          op_wr;
    logic          op_boot;

    logic [1:0]    req_m;
    logic          adv;
    logic          win;
    logic [1:0]    win_oh;
    logic [1:0]    owner_oh;
    logic [M-1:0]  wdata_w;
    logic          done;

    // A requester still holds req in the cycle its gnt is visible.
    assign req_m    = req & ~gnt;
    assign adv      = (state == S_IDLE) && (|req_m);
    assign done     = efc_rd_done | efc_wr_done;
    assign lock     = shadow[LOCK_BIT];
    assign win_oh   = win ? 2'b10 : 2'b01;
    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign wdata_w  = win ? req_wdata[REQ_HOST*M +: M]
                          : req_wdata[REQ_BOOT*M +: M];

    efuse_rr_arb u_arb (
        .clk     (clk_div2),
        .rst     (rst),
        .req     (req_m),
        .advance (adv),
        .gnt_idx (win)
    );

    always_ff @(posedge clk_div2 or posedge rst) begin
        if (rst) begin
            state       <= S_BOOT;
            cnt         <= '0;
            owner       <= 1'b0;
            op_wr       <= 1'b0;
            op_boot     <= 1'b0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            shadow      <= '0;
            boot_done   <= 1'b0;
            err_sticky  <= 1'b0;
            efc_rd      <= 1'b0;
            efc_wr      <= 1'b0;
            efc_ack     <= 1'b0;
            efc_data_in <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            efc_rd    <= 1'b0;
            efc_wr    <= 1'b0;
            efc_ack   <= 1'b0;
            unique case (state)
                S_BOOT: begin
                    efc_rd  <= 1'b1;
                    op_boot <= 1'b1;
                    op_wr   <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_IDLE: begin
                    if (adv) begin
                        gnt     <= win_oh;
                        owner   <= win;
                        op_boot <= 1'b0;
                        op_wr   <= req_wr[win];
                        cnt     <= '0;
                        if (req_wr[win] && lock) begin
                            rsp_valid <= win_oh;
                            rsp_err   <= 1'b1;
                        end else if (req_wr[win]) begin
                            efc_wr      <= 1'b1;
                            efc_data_in <= wdata_w;
                            state       <= S_WAIT_DONE;
                        end else begin
                            efc_rd <= 1'b1;
                            state  <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        efc_ack <= 1'b1;
                        if (!op_wr) begin
                            shadow    <= efc_data_out;
                            rsp_rdata <= efc_data_out;
                        end
                        if (op_boot) begin
                            boot_done <= 1'b1;
                        end else begin
                            rsp_valid <= owner_oh;
                        end
                        state <= S_ACK;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_sticky <= 1'b1;
                        if (op_boot) begin
                            boot_done <= 1'b1;
                        end else begin
                            rsp_valid <= owner_oh;
                            rsp_err   <= 1'b1;
                        end
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    efc_data_in <= '0;
                    state       <= S_GAP;
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    // Late completion of a timed-out op is acked and dropped.
                    if (done) begin
                        efc_ack <= 1'b1;
                        state   <= S_ACK;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_access_arbiter.sv
// Directed bench for efuse_access_arbiter with a behavioural
// efuse_controller model; TIMEOUT is shortened to 64 cycles.
module tb_efuse_access_arbiter;

    localparam int M  = 32;
    localparam int TO = 64;

    logic           clk_div2 = 1'b0;
    logic           rst;
    logic [1:0]     req;
    logic [1:0]     req_wr;
    logic [2*M-1:0] req_wdata;
    logic [1:0]     gnt;
    logic [1:0]     rsp_valid;
    logic           rsp_err;
    logic [M-1:0]   rsp_rdata;
    logic [M-1:0]   shadow;
    logic           boot_done;
    logic           err_sticky;
    logic           lock;
    logic           efc_rd;
    logic           efc_wr;
    logic           efc_ack;
    logic [M-1:0]   efc_data_in;
    logic [M-1:0]   efc_data_out;
    logic           efc_rd_done;
    logic           efc_wr_done;

    efuse_access_arbiter #(.M(M), .TIMEOUT(TO), .LOCK_BIT(31)) dut (
        .clk_div2     (clk_div2),
        .rst          (rst),
        .req          (req),
        .req_wr       (req_wr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .shadow       (shadow),
        .boot_done    (boot_done),
        .err_sticky   (err_sticky),
        .lock         (lock),
        .efc_rd       (efc_rd),
        .efc_wr       (efc_wr),
        .efc_ack      (efc_ack),
        .efc_data_in  (efc_data_in),
        .efc_data_out (efc_data_out),
        .efc_rd_done  (efc_rd_done),
        .efc_wr_done  (efc_wr_done)
    );

    always #5 clk_div2 = ~clk_div2;

    // Controller model: done appears m_delay+1 cycles after the start pulse.
    logic [M-1:0] m_data;
    int           m_delay;
    logic         m_silent;
    logic         m_busy;
    logic         m_wr;
    int           m_cnt;
    int           n_rd = 0;
    int           n_wr = 0;
    int           n_ack = 0;
    int           n_rv = 0;

    always @(posedge clk_div2 or posedge rst) begin
        if (rst) begin
            efc_rd_done  <= 1'b0;
            efc_wr_done  <= 1'b0;
            efc_data_out <= '0;
            m_busy       <= 1'b0;
            m_wr         <= 1'b0;
            m_cnt        <= 0;
        end else begin
            if (efc_ack) begin
                efc_rd_done <= 1'b0;
                efc_wr_done <= 1'b0;
            end
            if (efc_rd || efc_wr) begin
                m_busy <= 1'b1;
                m_wr   <= efc_wr;
                m_cnt  <= m_delay;
            end else if (m_busy) begin
                if (m_cnt != 0) begin
                    m_cnt <= m_cnt - 1;
                end else if (!m_silent) begin
                    m_busy <= 1'b0;
                    if (m_wr) begin
                        efc_wr_done <= 1'b1;
                    end else begin
                        efc_rd_done  <= 1'b1;
                        efc_data_out <= m_data;
                    end
                end
            end
        end
    end

    always @(posedge clk_div2) begin
        if (efc_rd) n_rd <= n_rd + 1;
        if (efc_wr) n_wr <= n_wr + 1;
        if (efc_ack) n_ack <= n_ack + 1;
        if (|rsp_valid) n_rv <= n_rv + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " ctrl"},
            {53'd0, gnt, rsp_valid, rsp_err, boot_done, err_sticky,
             lock, efc_rd, efc_wr, efc_ack}, 64'd0);
        chk({nm, " rdata/shadow"}, {rsp_rdata, shadow}, 64'd0);
        chk({nm, " data_in"}, {32'd0, efc_data_in}, 64'd0);
    endtask

    task automatic wait_gnt(input int p, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_div2);
            if (gnt[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int p, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_div2);
            if (rsp_valid[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          mdelay;
        logic [31:0] exp_shadow;
    } vec_t;

    task automatic run_vec(input vec_t v, input int i);
        bit ok;
        int n0;
        m_data  = v.mdata;
        m_delay = v.mdelay;
        n0      = n_rd + n_wr;
        req_wr[v.port]              = v.wr;
        req_wdata[v.port*32 +: 32]  = v.wdata;
        req[v.port]                 = 1'b1;
        wait_gnt(v.port, ok);
        chk($sformatf("v%0d gnt", i), {63'd0, ok}, 64'd1);
        chk($sformatf("v%0d start", i), {62'd0, efc_wr, efc_rd},
            v.wr ? 64'd2 : 64'd1);
        req[v.port] = 1'b0;
        wait_rsp(v.port, ok);
        chk($sformatf("v%0d rsp", i), {62'd0, ok, rsp_err}, 64'd2);
        if (!v.wr) chk($sformatf("v%0d rdata", i), {32'd0, rsp_rdata},
                       {32'd0, v.mdata});
        chk($sformatf("v%0d shadow", i), {32'd0, shadow},
            {32'd0, v.exp_shadow});
        chk($sformatf("v%0d issues", i), 64'(n_rd + n_wr - n0), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        int n0;
        int k;
        int bad;
        int a0;
        int rv0;

        vecs[0] = '{0, 1'b0, 32'h0,         32'h1234_5678, 5, 32'h1234_5678};
        vecs[1] = '{1, 1'b0, 32'h0,         32'h0BAD_F00D, 0, 32'h0BAD_F00D};
        vecs[2] = '{0, 1'b1, 32'h55AA_55AA, 32'hFFFF_FFFF, 3, 32'h0BAD_F00D};
        vecs[3] = '{1, 1'b1, 32'h7FFF_0001, 32'hFFFF_FFFF, 1, 32'h0BAD_F00D};
        vecs[4] = '{1, 1'b0, 32'h0,         32'h00C0_FFEE, 2, 32'h00C0_FFEE};
        vecs[5] = '{0, 1'b0, 32'h0,         32'h7FFF_FFFF, 7, 32'h7FFF_FFFF};

        rst       = 1'b1;
        req       = '0;
        req_wr    = '0;
        req_wdata = '0;
        m_silent  = 1'b0;
        m_delay   = 20;
        m_data    = 32'h0000_00A5;

        // Boot read after reset
        repeat (3) @(negedge clk_div2);
        chk_zero("reset");
        rst = 1'b0;
        ok  = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_div2);
            if (boot_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("boot done", {63'd0, ok}, 64'd1);
        repeat (3) @(negedge clk_div2);
        chk("boot rd/ack/rv", {32'(n_rd), 32'(n_ack)}, {32'd1, 32'd1});
        chk("boot rv", 64'(n_rv), 64'd0);
        chk("boot shadow", {31'd0, lock, shadow}, {31'd0, 1'b0, 32'hA5});
        chk("boot err", {63'd0, err_sticky}, 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Tie after a port 0 grant: port 1 goes first
        n0      = n_rd + n_wr;
        m_delay = 2;
        m_data  = 32'h0000_1111;
        req_wr  = 2'b00;
        req     = 2'b11;
        wait_gnt(1, ok);
        chk("tie first", {61'd0, ok, gnt}, {61'd0, 1'b1, 2'b10});
        req[1] = 1'b0;
        wait_rsp(1, ok);
        chk("tie rsp1", {63'd0, ok}, 64'd1);
        wait_gnt(0, ok);
        chk("tie second", {61'd0, ok, gnt}, {61'd0, 1'b1, 2'b01});
        req[0] = 1'b0;
        wait_rsp(0, ok);
        chk("tie rsp0", {63'd0, ok}, 64'd1);
        chk("tie issues", 64'(n_rd + n_wr - n0), 64'd2);

        // Long write: data held until done, cleared after ack
        m_delay          = 50;
        req_wr[1]        = 1'b1;
        req_wdata[63:32] = 32'h0000_F00F;
        req[1]           = 1'b1;
        wait_gnt(1, ok);
        chk("lw start", {31'd0, ok, efc_wr, efc_data_in},
            {31'd0, 1'b1, 1'b1, 32'hF00F});
        req[1] = 1'b0;
        bad    = 0;
        ok     = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_div2);
            if (rsp_valid[1]) begin
                ok = 1'b1;
                break;
            end
            if (efc_data_in !== 32'hF00F) bad++;
        end
        chk("lw held", 64'(bad), 64'd0);
        chk("lw rsp", {30'd0, ok, efc_ack, rsp_err, efc_data_in},
            {30'd0, 1'b1, 1'b1, 1'b0, 32'hF00F});
        @(negedge clk_div2);
        chk("lw clear", {32'd0, efc_data_in}, 64'd0);
        chk("lw shadow", {32'd0, shadow}, {32'd0, 32'h1111});

        // Timeout on a silent controller, then a late done
        m_silent  = 1'b1;
        m_delay   = 0;
        req_wr[0] = 1'b0;
        req[0]    = 1'b1;
        wait_gnt(0, ok);
        req[0] = 1'b0;
        k      = 0;
        while (!rsp_valid[0] && k < 200) begin
            @(negedge clk_div2);
            k++;
        end
        chk("to latency", 64'(k), 64'(TO));
        chk("to err", {62'd0, rsp_err, err_sticky}, 64'd3);
        chk("to shadow", {32'd0, shadow}, {32'd0, 32'h1111});
        repeat (5) @(negedge clk_div2);
        a0       = n_ack;
        rv0      = n_rv;
        m_silent = 1'b0;
        repeat (10) @(negedge clk_div2);
        chk("late ack", 64'(n_ack - a0), 64'd1);
        chk("late no rv", 64'(n_rv - rv0), 64'd0);

        // Reset in the middle of WAIT_DONE, reboot with lock set
        m_delay = 30;
        req[0]  = 1'b1;
        wait_gnt(0, ok);
        req[0] = 1'b0;
        repeat (5) @(negedge clk_div2);
        rst = 1'b1;
        #1;
        chk_zero("mid rst");
        m_data  = 32'h8000_0000;
        m_delay = 10;
        n0      = n_rd;
        rv0     = n_rv;
        @(negedge clk_div2);
        rst = 1'b0;
        ok  = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_div2);
            if (boot_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reboot done", {63'd0, ok}, 64'd1);
        repeat (3) @(negedge clk_div2);
        chk("reboot rd", 64'(n_rd - n0), 64'd1);
        chk("reboot shadow", {30'd0, lock, err_sticky, shadow},
            {30'd0, 1'b1, 1'b0, 32'h8000_0000});
        chk("reboot no rv", 64'(n_rv - rv0), 64'd0);

        // Locked write is rejected in the grant cycle
        n0               = n_wr;
        req_wr[1]        = 1'b1;
        req_wdata[63:32] = 32'h0000_1234;
        req[1]           = 1'b1;
        wait_gnt(1, ok);
        chk("lock rej", {59'd0, ok, rsp_valid, rsp_err, efc_wr},
            {59'd0, 1'b1, 2'b10, 1'b1, 1'b0});
        req[1] = 1'b0;
        repeat (5) @(negedge clk_div2);
        chk("lock no wr", 64'(n_wr - n0), 64'd0);
        chk("lock shadow", {32'd0, shadow}, {32'd0, 32'h8000_0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
